// File: rtl/nco_voice_scheduler.sv
// Shares one quarter-wave sine ROM between VOICES NCO voices. Each sample
// frame steps every voice through the ROM, then emits the mixed signed sample.
module nco_voice_scheduler #(
  parameter int BITSIZE = 24,
  parameter int PHASE   = 17,
  parameter int TABLE   = 12,
  parameter int VBITS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [VBITS-1:0]   cfg_voice,
  input  logic [PHASE-1:0]   cfg_step,
  input  logic [8:0]         cfg_gain,
  input  logic               cfg_en,
  output logic [TABLE-1:0]   rom_addr,
  input  logic [BITSIZE-1:0] rom_data,
  output logic [BITSIZE-1:0] sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int VOICES = 2**VBITS;
  localparam int ACCW   = BITSIZE + VBITS + 1;
  localparam int PRODW  = BITSIZE + 9;
  localparam logic [VBITS-1:0] LAST_VOICE = VBITS'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [VBITS-1:0]        v_reg;
  logic [VBITS-1:0]        v_inc;
  logic signed [ACCW-1:0]  acc_reg;
  logic                    frame_start;

  logic [VOICES-1:0][PHASE-1:0] phase_all;
  logic [VOICES-1:0][PHASE-1:0] step_all;
  logic [VOICES-1:0][8:0]       gain_all;
  logic [VOICES-1:0]            en_all;

  logic [PRODW-1:0]        prod;
  logic signed [ACCW-1:0]  term_mag;
  logic signed [ACCW-1:0]  term;

  // Quadrant fold: bit PHASE-2 mirrors the index, bit PHASE-1 is the sign.
  function automatic logic [TABLE-1:0] idx_of(input logic [PHASE-1:0] p);
    logic [TABLE-1:0] f;
    f = p[PHASE-3 -: TABLE];
    return p[PHASE-2] ? ~f : f;
  endfunction

  assign frame_start = (state_reg == IDLE) && sample_tick;
  assign v_inc       = v_reg + VBITS'(1);

  generate
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
      logic [PHASE-1:0] phase_reg, step_sh_reg, step_act_reg;
      logic [8:0]       gain_sh_reg, gain_act_reg;
      logic             en_sh_reg, en_act_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          phase_reg    <= '0;
          step_sh_reg  <= '0;
          step_act_reg <= '0;
          gain_sh_reg  <= '0;
          gain_act_reg <= '0;
          en_sh_reg    <= 1'b0;
          en_act_reg   <= 1'b0;
        end else begin
          if (cfg_we && cfg_voice == VBITS'(gi)) begin
            step_sh_reg <= cfg_step;
            gain_sh_reg <= (cfg_gain > 9'd256) ? 9'd256 : cfg_gain;
            en_sh_reg   <= cfg_en;
          end
          // The active set reads the shadow before any same-cycle write lands.
          if (frame_start) begin
            step_act_reg <= step_sh_reg;
            gain_act_reg <= gain_sh_reg;
            en_act_reg   <= en_sh_reg;
          end
          if (state_reg == MAC && v_reg == VBITS'(gi)) begin
            phase_reg <= en_act_reg ? phase_reg + step_act_reg : '0;
          end
        end
      end

      assign phase_all[gi] = phase_reg;
      assign step_all[gi]  = step_act_reg;
      assign gain_all[gi]  = gain_act_reg;
      assign en_all[gi]    = en_act_reg;
    end
  endgenerate

  // Product is non-negative, so the >>8 is exact as an arithmetic shift.
  assign prod     = {9'd0, rom_data} * {{BITSIZE{1'b0}}, gain_all[v_reg]};
  assign term_mag = ACCW'(prod >> 8);

  always_comb begin
    term = '0;
    if (en_all[v_reg]) begin
      term = phase_all[v_reg][PHASE-1] ? -term_mag : term_mag;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (sample_tick) state_next = FETCH;
      FETCH:   state_next = MAC;
      MAC:     state_next = (v_reg == LAST_VOICE) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg        <= '0;
      acc_reg      <= '0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state_reg != IDLE) begin
        overrun <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            v_reg    <= '0;
            acc_reg  <= '0;
            rom_addr <= idx_of(phase_all[0]);
          end
        end
        MAC: begin
          acc_reg <= acc_reg + term;
          if (v_reg != LAST_VOICE) begin
            v_reg    <= v_inc;
            rom_addr <= idx_of(phase_all[v_inc]);
          end
        end
        DONE: begin
          sample       <= BITSIZE'(acc_reg >>> VBITS);
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Directed bench for nco_voice_scheduler: stimulus pushes expected samples,
// a negedge monitor pops and checks them along with frame latency.
module tb_nco_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0;
  logic [16:0] cfg_step = '0;
  logic [8:0]  cfg_gain = '0;
  logic        cfg_en = 1'b0;
  logic [11:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rom_mode = 0;

  typedef struct {
    int s;
    int tcyc;
  } exp_t;
  exp_t exp_q[$];

  nco_voice_scheduler #(.BITSIZE(24), .PHASE(17), .TABLE(12), .VBITS(2)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_step(cfg_step),
    .cfg_gain(cfg_gain), .cfg_en(cfg_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM: T[a] = 1000*a + 12 (mode 0) or constant 1000 (mode 1), 1-cycle read.
  always @(posedge clk) begin
    if (rom_mode == 1) rom_data <= 24'd1000;
    else               rom_data <= 24'(int'(rom_addr) * 1000 + 12);
  end

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_valid: got sample %0d expected no output", $signed(sample));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame: sample %0d expected %0d", $signed(sample), e.s);
        check("sample", int'($signed(sample)), e.s);
        check("latency", cyc - e.tcyc, 9);
      end
    end
  end

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int v, input int step, input int gain, input bit en);
    cfg_voice = 2'(v);
    cfg_step  = 17'(step);
    cfg_gain  = 9'(gain);
    cfg_en    = en;
    cfg_we    = 1'b1;
    tick_clk();
    cfg_we    = 1'b0;
  endtask

  // Returns positioned in the FETCH cycle of voice 0.
  task automatic start_frame(input bit push, input int exp_s);
    exp_t e;
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    if (push) begin
      e.s    = exp_s;
      e.tcyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 40) begin
      tick_clk();
      n++;
    end
    if (busy) check("busy_timeout", 1, 0);
    tick_clk();
  endtask

  task automatic frame(input int exp_s, input int exp_addr);
    start_frame(1'b1, exp_s);
    check("rom_addr_v0", int'(rom_addr), exp_addr);
    wait_idle();
  endtask

  initial begin
    repeat (3) tick_clk();
    rst = 1'b0;
    tick_clk();
    check("reset_sample", int'(sample), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_rom_addr", int'(rom_addr), 0);

    // Voice 0 alone, quarter-turn steps through all four quadrants.
    cfg(0, 32768, 256, 1'b1);
    frame(3, 0);
    frame(1023753, 4095);
    frame(-3, 0);
    frame(-1023753, 4095);

    // Asynchronous reset during MAC of voice 2.
    frame(3, 0);
    start_frame(1'b0, 0);
    repeat (5) tick_clk();
    check("midframe_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    tick_clk();
    rst = 1'b0;
    repeat (15) tick_clk();
    cfg(0, 32768, 256, 1'b1);
    frame(3, 0);

    // Constant ROM, all voices at unity (voice 1 gain clamps from 300).
    rom_mode = 1;
    cfg(0, 0, 256, 1'b1);
    cfg(1, 0, 300, 1'b1);
    cfg(2, 0, 256, 1'b1);
    cfg(3, 0, 256, 1'b1);
    frame(1000, 4095);
    cfg(0, 0, 0, 1'b1);
    cfg(1, 0, 128, 1'b1);
    cfg(2, 0, 128, 1'b1);
    cfg(3, 0, 128, 1'b1);
    frame(375, 4095);

    // Disable everything to zero the phases, then the mid-frame step write.
    rom_mode = 0;
    cfg(0, 0, 0, 1'b0);
    cfg(1, 0, 0, 1'b0);
    cfg(2, 0, 0, 1'b0);
    cfg(3, 0, 0, 1'b0);
    frame(0, 4095);
    cfg(0, 8, 256, 1'b1);
    start_frame(1'b1, 3);
    check("rom_addr_v0", int'(rom_addr), 0);
    tick_clk();
    cfg_voice = 2'd0;
    cfg_step  = 17'd16;
    cfg_gain  = 9'd256;
    cfg_en    = 1'b1;
    cfg_we    = 1'b1;
    tick_clk();
    cfg_we    = 1'b0;
    wait_idle();
    frame(253, 1);
    frame(753, 3);

    // Second tick 3 cycles into a frame is dropped and flags overrun.
    check("overrun_before", int'(overrun), 0);
    start_frame(1'b1, 1253);
    check("rom_addr_v0", int'(rom_addr), 5);
    repeat (2) tick_clk();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    check("overrun_set", int'(overrun), 1);
    wait_idle();
    repeat (12) tick_clk();
    check("overrun_sticky", int'(overrun), 1);
    check("queue_drained", exp_q.size(), 0);

    // Near-full-scale step wraps phase downward through 2^17.
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    tick_clk();
    check("overrun_cleared", int'(overrun), 0);
    cfg(0, 131071, 256, 1'b1);
    cfg(1, 0, 256, 1'b1);
    frame(6, 0);
    for (int i = 0; i < 8; i++) frame(0, 0);
    frame(-250, 1);
    repeat (4) tick_clk();
    check("queue_drained_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nco_voice_scheduler.md
# nco_voice_scheduler

Time-multiplexed controller that shares one quarter-wave sine ROM between `VOICES` independent NCO voices. On each sample-frame strobe it sequences every voice through the shared ROM port. For each voice it folds the phase into a table index, applies sign and gain, and accumulates the result. It then presents one mixed signed sample to the I2S transmit path. It sits between the DAC-frame strobe logic and the `i2s_tx` left/right inputs, and replaces the single hard-wired NCO.

## Interface
Parameters:
- `BITSIZE`, 24: sample width; ROM word width.
- `PHASE`, 17: phase accumulator width.
- `TABLE`, 12: ROM address width (quarter-wave, 2^TABLE entries).
- `VBITS`, 2: voice index width; `VOICES` = 2^VBITS.

Ports:
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: asynchronous, active-high reset.
- `sample_tick`  in  1: one-cycle frame strobe, already synchronous to `clk`.
- `cfg_we`  in  1: config write strobe.
- `cfg_voice`  in  VBITS: voice addressed by the write.
- `cfg_step`  in  PHASE: phase increment per frame.
- `cfg_gain`  in  9: unsigned gain; 256 = unity; values above 256 are stored as 256.
- `cfg_en`  in  1: voice enable.
- `rom_addr`  out  TABLE: registered ROM address.
- `rom_data`  in  BITSIZE: unsigned ROM word; synchronous read with 1-cycle latency.
- `sample`  out  BITSIZE: signed mixed sample; held between updates.
- `sample_valid`  out  1: one-cycle pulse when `sample` updates.
- `busy`  out  1: high in every state except IDLE.
- `overrun`  out  1: sticky; set when `sample_tick` arrives while busy.

## Operation
- Per-voice registers:
  - Shadow set: step, gain, en. Written by `cfg_we` at any time.
  - Active set: copied from the shadow set at each IDLE→FETCH transition. Writes made mid-frame therefore take effect on the next frame.
  - `phase[v]`: PHASE bits.
- State machine: IDLE → FETCH → MAC → FETCH … → DONE → IDLE. A voice counter `v` runs from 0 to VOICES-1.
- IDLE:
  - On `sample_tick`: latch the active set, set `v` = 0, go to FETCH.
  - Load `rom_addr` with `idx(v)`, where:
    - `idx` = `phase[v][PHASE-3:PHASE-TABLE-2]` when `phase[v][PHASE-2]` = 0.
    - Otherwise `idx` is the bitwise inverse of that field.
- FETCH: `rom_addr` is stable for the whole cycle; the ROM samples it at the end of the cycle.
- MAC: `rom_data` is valid.
  - `term` = `rom_data` × gain, signed, full width, arithmetic shift right by 8.
  - Negate `term` if `phase[v][PHASE-1]` = 1.
  - `term` = 0 if the voice is disabled.
  - `acc` += `term`. `acc` is BITSIZE+VBITS+1 bits, signed, cleared on entering FETCH for v = 0.
  - Update phase:
    - Enabled voice: `phase[v]` += step, modulo 2^PHASE, wrapping silently.
    - Disabled voice: `phase[v]` is forced to 0.
  - If `v` < VOICES-1: increment `v`, load `rom_addr` with the next `idx`, go to FETCH.
  - Otherwise go to DONE.
- DONE:
  - `sample` ← `acc` >>> VBITS (arithmetic), truncated to BITSIZE. With gains ≤ unity this cannot overflow.
  - Assert `sample_valid`; return to IDLE.
- `sample_tick` in any non-IDLE state is ignored and sets `overrun`; the frame in progress completes normally.
- `cfg_we` in the same cycle as the IDLE→FETCH latch: the new value is written to the shadow set only. It is not used this frame.

## Timing
- Reset values:
  - All outputs 0.
  - All phase, step, gain and en registers 0.
  - State IDLE.
- Reset is asynchronous. Asserting `rst` mid-frame aborts the frame immediately and produces no `sample_valid`.
- Latency: when `sample_tick` is sampled at edge t, `sample_valid` is high in the cycle following edge t + 2·VOICES + 1. With VOICES = 4, that is 9 cycles busy.
- Throughput: one frame per 2·VOICES + 2 cycles minimum. At 12.288 MHz with 48 kHz frames, the margin is large.
- Each frame uses the phase value from before its own increment, so the first frame after reset uses phase 0.

## Test plan
- Reset with `rst` pulsed mid-frame (asserted during MAC of v = 2):
  - `busy`, `sample`, `sample_valid`, `overrun` and `rom_addr` all 0 at once; no `sample_valid` afterwards.
  - On the next tick, voice 0 uses phase 0.
- Single voice 0, en = 1, gain = 256, step = 32768; four ticks:
  - `rom_addr` for voice 0 is 0, 4095, 0, 4095.
  - `sample` is T[0]>>>2, T[4095]>>>2, −T[0]>>>2, −T[4095]>>>2, where T is the ROM contents.
- All four voices enabled, step = 0, gain = 256, ROM returns constant 1000 → `sample` = 1000.
- Same setup, voices 1–3 gain = 128, voice 0 gain = 0 → `sample` = (3·500)>>>2 = 375.
- Config write to voice 0 step during MAC of v = 0:
  - The current frame's phase increment uses the old step.
  - The next frame uses the new step.
- `sample_tick` asserted 3 cycles after a previous tick:
  - `overrun` = 1 and stays high.
  - Exactly one `sample_valid` at the 9-cycle latency; the second tick is dropped.
- Step = 131071 on voice 0 → the phase wraps to 131070 after frame 2; no other state is disturbed.
